mips_cpu_bus_core: RTL and testbench
====================================

Name: mips_cpu_bus_core

Overview:
- Multicycle, non-pipelined MIPS-I subset CPU with a single Avalon-style memory-mapped master port shared by instruction fetch and data access.
- Sits at the top of the CPU subsystem; the bus connects to a unified memory/interconnect.
- Exports `$v0` (r2) and an `active` flag for test and debug observation.
- The CPU halts when it jumps to address 0.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC loaded on reset.

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset; reset=0 clears state immediately, reset=1 runs.
- active  out  1  high while running; low once halted.
- register_v0  out  32  live copy of GPR r2.
- address  out  32  byte address; word accesses are word aligned.
- write  out  1  write strobe.
- read  out  1  read strobe; never asserted together with write.
- waitrequest  in  1  slave stall; hold address/read/write/writedata/byteenable stable while high.
- writedata  out  32  store data.
- byteenable  out  4  lane enables, bit0 = bits 7:0.
- readdata  in  32  read data, sampled on the edge where read=1 and waitrequest=0.

Behaviour:
- Reset values:
  - PC = RESET_VECTOR, all 32 GPRs = 0, state = FETCH.
  - active = 1, read = write = 0, byteenable = 4'b1111, writedata = 0.
  - register_v0 = 0.
- State machine: FETCH -> EXEC -> (MEM) -> FETCH, plus terminal HALT.
- FETCH:
  - read = 1, address = PC, byteenable = 1111.
  - Stay in FETCH while waitrequest = 1.
  - When waitrequest = 0, latch readdata into IR and go to EXEC.
- EXEC (one cycle):
  - Decode IR and read rs/rt.
  - ALU ops write rd/rt this cycle, then go to FETCH.
  - lw/sw compute base + sign-extended imm16, then go to MEM.
- MEM:
  - lw: read = 1, address = effective address, byteenable = 1111. When waitrequest = 0, write readdata into rt and go to FETCH.
  - sw: write = 1, writedata = rt, byteenable = 1111. Complete when waitrequest = 0.
  - Data fetch latency is therefore ≥ 1 cycle after EXEC.
- Supported instructions:
  - R-type: addu, subu, and, or, xor, slt, sltu, sll, srl, sra, jr.
  - I-type: addiu, andi, ori, xori, slti, sltiu, lui, lw, sw, beq, bne.
  - J-type: j, jal (link into r31 = PC + 8).
- Arithmetic:
  - 32-bit wraparound, no overflow traps.
  - addiu/slti/sltiu/lw/sw sign-extend imm16; andi/ori/xori zero-extend.
  - lui sets rt = {imm, 16'h0}.
  - slt is signed; sltu/sltiu compare unsigned after sign-extension.
  - Shifts use shamt.
- Register file:
  - r0 reads 0; writes to r0 are discarded.
  - register_v0 reflects r2 combinationally from the register file.
  - A value written in EXEC or MEM is visible on register_v0 the cycle after the write edge.
- Branch delay slot:
  - Branches and jumps execute the next sequential instruction (the delay slot) before the PC takes the target.
  - Branch target = PC + 4 + (sext(imm) << 2).
  - j target = {PC+4[31:28], idx, 2'b00}.
  - A branch or jump inside a delay slot is undefined; implement it as if the second one wins.
- Halt:
  - When a jump or jr target of 0 would be loaded into the PC, execute the delay slot first.
  - Then enter HALT: active = 0, read = write = 0 thereafter, until reset.
- Unknown opcodes execute as NOP.
- Reset mid-access drops read/write immediately; there is no bus completion.

Optional Feature:
- Macro: MIPS_BYTE_ACCESS_EN.
- When defined, add lb, lbu, lh, lhu, sb, sh.
  - Loads: read uses byteenable = 1111; select lane by address[1:0] and sign- or zero-extend.
  - sb drives byteenable = 1 << address[1:0] with data replicated on all lanes.
  - sh drives byteenable = 0011 or 1100 from address[1].
  - address is forced word-aligned (low 2 bits = 0) on the bus.
- When undefined, these opcodes decode as NOP.

Test Plan:
1. Reset release: fetch is read = 1, address = 32'hBFC00000, byteenable = 1111, write = 0; register_v0 = 0; active = 1.
2. Fetch `lw r2, 0(r3)` (32'h8C620000) with r3 = 0, then return 9 on the data read → data phase shows read = 1, write = 0, address = 0; register_v0 = 9.
3. After test 2, fetch `addiu r2, r2, 5` (32'h24420005) → register_v0 = 14 within 4 cycles.
4. Fetch `lui r2, 0xFFFF` (32'h3C02FFFF), then `addiu r2, r2, 1` (32'h24420001) → register_v0 = 32'hFFFF0001, then 32'hFFFF0002.
5. waitrequest held high for 5 cycles during fetch and during sw → address/read/write/writedata stay stable; the instruction still completes correctly.
6. `jr r0` (32'h00000008) followed by delay slot `addiu r2, r0, 7` → register_v0 = 7, then active = 0 and no further read/write.

Source files
------------

// File: rtl/mips_cpu_bus_core.sv
// mips_cpu_bus_core: multicycle (FETCH -> EXEC -> [MEM] -> FETCH) MIPS-I subset
// CPU with one Avalon-style master port shared by instruction fetch and data.
// The CPU halts when a jump target of 0 reaches the PC, after its delay slot.
//
// Ports:
//   clk          rising-edge system clock
//   reset        asynchronous active-low reset (0 = held in reset)
//   active       1 while running, 0 once halted
//   register_v0  live copy of GPR r2
//   address      bus byte address
//   read/write   bus strobes (never both high)
//   waitrequest  slave stall; bus outputs are held stable while high
//   writedata    store data
//   byteenable   lane enables, bit0 = bits 7:0
//   readdata     read data, taken when read=1 and waitrequest=0
//
// Optional build macro: MIPS_BYTE_ACCESS_EN adds lb/lbu/lh/lhu/sb/sh
// (undefined: those opcodes execute as NOP).
module mips_cpu_bus_core #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        active,
   output logic [31:0] register_v0,
   output logic [31:0] address,
   output logic        write,
   output logic        read,
   input  logic        waitrequest,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic [31:0] readdata
);

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

   state_t      state, state_nx;
   logic [31:0] pc, pc_nx, ir, tgt, ea, sdata;
   logic [3:0]  sbe;
   logic        pend;
   logic [31:0] regs [32];

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [31:0] rs_val, rt_val, sext, zext, pc4, ea_c;
   logic [31:0] alu_res, target, ld_data, st_data, bus_ea;
   logic [3:0]  st_be;
   logic [4:0]  alu_dst;
   logic        alu_wr, taken, is_ld, is_st;
   logic        wr_en;
   logic [4:0]  wr_idx;
   logic [31:0] wr_data;

   assign op     = ir[31:26];
   assign rs     = ir[25:21];
   assign rt     = ir[20:16];
   assign rd     = ir[15:11];
   assign shamt  = ir[10:6];
   assign funct  = ir[5:0];
   assign rs_val = regs[rs];
   assign rt_val = regs[rt];
   assign sext   = {{16{ir[15]}}, ir[15:0]};
   assign zext   = {16'h0000, ir[15:0]};
   assign pc4    = pc + 32'd4;
   assign ea_c   = rs_val + sext;

   // Decode / ALU; ir stays valid through MEM so is_ld/is_st hold there too.
   always_comb begin
      alu_res = '0;
      alu_dst = rt;
      alu_wr  = 1'b0;
      taken   = 1'b0;
      target  = '0;
      is_ld   = 1'b0;
      is_st   = 1'b0;
      case (op)
         6'h00: begin
            alu_dst = rd;
            alu_wr  = 1'b1;
            case (funct)
               6'h00: alu_res = rt_val << shamt;
               6'h02: alu_res = rt_val >> shamt;
               6'h03: alu_res = $signed(rt_val) >>> shamt;
               6'h08: begin alu_wr = 1'b0; taken = 1'b1; target = rs_val; end
               6'h21: alu_res = rs_val + rt_val;
               6'h23: alu_res = rs_val - rt_val;
               6'h24: alu_res = rs_val & rt_val;
               6'h25: alu_res = rs_val | rt_val;
               6'h26: alu_res = rs_val ^ rt_val;
               6'h2A: alu_res = {31'b0, $signed(rs_val) < $signed(rt_val)};
               6'h2B: alu_res = {31'b0, rs_val < rt_val};
               default: alu_wr = 1'b0;
            endcase
         end
         6'h02: begin taken = 1'b1; target = {pc4[31:28], ir[25:0], 2'b00}; end
         6'h03: begin
            taken   = 1'b1;
            target  = {pc4[31:28], ir[25:0], 2'b00};
            alu_wr  = 1'b1;
            alu_dst = 5'd31;
            alu_res = pc + 32'd8;
         end
         6'h04: begin taken = (rs_val == rt_val); target = pc4 + {sext[29:0], 2'b00}; end
         6'h05: begin taken = (rs_val != rt_val); target = pc4 + {sext[29:0], 2'b00}; end
         6'h09: begin alu_wr = 1'b1; alu_res = rs_val + sext; end
         6'h0A: begin alu_wr = 1'b1; alu_res = {31'b0, $signed(rs_val) < $signed(sext)}; end
         6'h0B: begin alu_wr = 1'b1; alu_res = {31'b0, rs_val < sext}; end
         6'h0C: begin alu_wr = 1'b1; alu_res = rs_val & zext; end
         6'h0D: begin alu_wr = 1'b1; alu_res = rs_val | zext; end
         6'h0E: begin alu_wr = 1'b1; alu_res = rs_val ^ zext; end
         6'h0F: begin alu_wr = 1'b1; alu_res = {ir[15:0], 16'h0000}; end
         6'h23: is_ld = 1'b1;
         6'h2B: is_st = 1'b1;
`ifdef MIPS_BYTE_ACCESS_EN
         6'h20, 6'h21, 6'h24, 6'h25: is_ld = 1'b1;
         6'h28, 6'h29:               is_st = 1'b1;
`endif
         default: ;
      endcase
   end

   // Lane selection for loads and store data/enables
`ifdef MIPS_BYTE_ACCESS_EN
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   always_comb begin
      case (ea[1:0])
         2'd0:    ld_byte = readdata[7:0];
         2'd1:    ld_byte = readdata[15:8];
         2'd2:    ld_byte = readdata[23:16];
         default: ld_byte = readdata[31:24];
      endcase
      ld_half = ea[1] ? readdata[31:16] : readdata[15:0];
      case (op)
         6'h20:   ld_data = {{24{ld_byte[7]}}, ld_byte};
         6'h24:   ld_data = {24'h000000, ld_byte};
         6'h21:   ld_data = {{16{ld_half[15]}}, ld_half};
         6'h25:   ld_data = {16'h0000, ld_half};
         default: ld_data = readdata;
      endcase
      st_data = rt_val;
      st_be   = '1;
      case (op)
         6'h28: begin st_data = {4{rt_val[7:0]}};  st_be = 4'b0001 << ea_c[1:0]; end
         6'h29: begin st_data = {2{rt_val[15:0]}}; st_be = ea_c[1] ? 4'b1100 : 4'b0011; end
         default: ;
      endcase
   end
   assign bus_ea = {ea[31:2], 2'b00};
`else
   assign ld_data = readdata;
   assign st_data = rt_val;
   assign st_be   = '1;
   assign bus_ea  = ea;
`endif

   // Delay slot: a taken branch outside a slot arms pend/tgt; the slot then
   // moves to tgt. A taken branch inside a slot overrides the pending target.
   always_comb begin
      if (taken && pend) pc_nx = target;
      else if (pend)     pc_nx = tgt;
      else               pc_nx = pc4;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_FETCH: if (!waitrequest) state_nx = S_EXEC;
         S_EXEC: begin
            if (is_ld || is_st)     state_nx = S_MEM;
            else if (pc_nx == '0)   state_nx = S_HALT;
            else                    state_nx = S_FETCH;
         end
         S_MEM: if (!waitrequest) state_nx = (pc == '0) ? S_HALT : S_FETCH;
         default: state_nx = S_HALT;
      endcase
   end

   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = '0;
      wr_data = '0;
      if (state == S_EXEC && alu_wr) begin
         wr_en = 1'b1; wr_idx = alu_dst; wr_data = alu_res;
      end else if (state == S_MEM && is_ld && !waitrequest) begin
         wr_en = 1'b1; wr_idx = rt; wr_data = ld_data;
      end
   end

   // Strobes are gated by reset so an access drops the moment reset asserts.
   assign read        = reset && (state == S_FETCH || (state == S_MEM && is_ld));
   assign write       = reset && state == S_MEM && is_st;
   assign address     = (state == S_MEM) ? bus_ea : pc;
   assign byteenable  = (state == S_MEM && is_st) ? sbe : 4'b1111;
   assign writedata   = sdata;
   assign active      = (state != S_HALT);
   assign register_v0 = regs[2];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_FETCH;
         pc    <= RESET_VECTOR;
         ir    <= '0;
         tgt   <= '0;
         pend  <= 1'b0;
         ea    <= '0;
         sdata <= '0;
         sbe   <= '1;
      end else begin
         state <= state_nx;
         if (state == S_FETCH && !waitrequest) ir <= readdata;
         if (state == S_EXEC) begin
            pc    <= pc_nx;
            pend  <= taken && !pend;
            if (taken && !pend) tgt <= target;
            ea    <= ea_c;
            sdata <= st_data;
            sbe   <= st_be;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
      end else if (wr_en && wr_idx != 5'd0) begin
         regs[wr_idx] <= wr_data;
      end
   end

endmodule

// File: tb/tb_mips_cpu_bus_core.sv
// Self-checking bench for mips_cpu_bus_core: acts as the bus slave, feeds a
// short program instruction by instruction and checks bus activity and r2.
module tb_mips_cpu_bus_core;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        waitrequest = 1'b1;
   logic [31:0] readdata = '0;
   logic        active, write, read;
   logic [31:0] register_v0, address, writedata;
   logic [3:0]  byteenable;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_q [$];
   logic [31:0] pc_model = 32'hBFC00000;
   logic [31:0] exp;

   logic [31:0] b_addr, b_wd;
   logic        b_rd, b_wr;
   logic [3:0]  b_be;
   bit          b_stable, b_ok;

   mips_cpu_bus_core #(.RESET_VECTOR(32'hBFC00000)) dut (
      .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
      .address(address), .write(write), .read(read), .waitrequest(waitrequest),
      .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
   );

   always #5 clk = ~clk;

   // Waits (bounded) for a bus request, stalls it 'waits' cycles while
   // watching its outputs, then completes it with rdata.
   task automatic serve(input logic [31:0] rdata, input int waits);
      b_ok = 1'b0;
      b_stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (read || write) begin b_ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!b_ok) return;
      b_addr = address; b_rd = read; b_wr = write; b_wd = writedata; b_be = byteenable;
      for (int i = 0; i < waits; i++) begin
         @(negedge clk);
         if (address !== b_addr || read !== b_rd || write !== b_wr ||
             writedata !== b_wd || byteenable !== b_be) b_stable = 1'b0;
      end
      readdata = rdata;
      waitrequest = 1'b0;
      @(negedge clk);
      waitrequest = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (read !== 1'b0) begin n_err++; $display("FAIL rst_read: got %b expected 0", read); end
      n_cmp++; if (write !== 1'b0) begin n_err++; $display("FAIL rst_write: got %b expected 0", write); end
      n_cmp++; if (active !== 1'b1) begin n_err++; $display("FAIL rst_active: got %b expected 1", active); end
      n_cmp++; if (register_v0 !== 32'h0) begin n_err++; $display("FAIL rst_v0: got %h expected 0", register_v0); end
      n_cmp++; if (writedata !== 32'h0) begin n_err++; $display("FAIL rst_wd: got %h expected 0", writedata); end
      reset = 1'b1;
      #1;
      n_cmp++; if (read !== 1'b1) begin n_err++; $display("FAIL rel_read: got %b expected 1", read); end
      n_cmp++; if (address !== 32'hBFC00000) begin n_err++; $display("FAIL rel_addr: got %h expected bfc00000", address); end
      n_cmp++; if (byteenable !== 4'b1111) begin n_err++; $display("FAIL rel_be: got %b expected 1111", byteenable); end
      n_cmp++; if (write !== 1'b0) begin n_err++; $display("FAIL rel_write: got %b expected 0", write); end
   endtask

   task automatic test_lw();
      exp_q.push_back(pc_model);
      serve(32'h8C620000, 0);       // lw r2, 0(r3)
      pc_model += 4;
      exp = exp_q.pop_front();
      n_cmp++; if (b_ok !== 1'b1 || b_addr !== exp) begin n_err++; $display("FAIL lw_fetch: got %h ok=%b expected %h", b_addr, b_ok, exp); end
      exp_q.push_back(32'h0);
      exp_q.push_back(32'd9);
      serve(32'd9, 0);
      exp = exp_q.pop_front();
      n_cmp++; if (b_ok !== 1'b1 || b_addr !== exp) begin n_err++; $display("FAIL lw_addr: got %h ok=%b expected %h", b_addr, b_ok, exp); end
      n_cmp++; if (b_rd !== 1'b1 || b_wr !== 1'b0) begin n_err++; $display("FAIL lw_strobes: got rd=%b wr=%b expected rd=1 wr=0", b_rd, b_wr); end
      n_cmp++; if (b_be !== 4'b1111) begin n_err++; $display("FAIL lw_be: got %b expected 1111", b_be); end
      exp = exp_q.pop_front();
      n_cmp++; if (register_v0 !== exp) begin n_err++; $display("FAIL lw_v0: got %h expected %h", register_v0, exp); end
   endtask

   task automatic test_addiu();
      exp_q.push_back(pc_model);
      exp_q.push_back(32'd14);
      serve(32'h24420005, 0);       // addiu r2, r2, 5
      pc_model += 4;
      exp = exp_q.pop_front();
      n_cmp++; if (b_ok !== 1'b1 || b_addr !== exp) begin n_err++; $display("FAIL addiu_fetch: got %h expected %h", b_addr, exp); end
      exp = exp_q.pop_front();
      for (int i = 0; i < 4; i++) begin
         if (register_v0 === exp) break;
         @(negedge clk);
      end
      n_cmp++; if (register_v0 !== exp) begin n_err++; $display("FAIL addiu_v0: got %h expected %h", register_v0, exp); end
   endtask

   task automatic test_lui();
      logic [31:0] prog [3] = '{32'h3C02FFFF, 32'h24420001, 32'h24420001};
      logic [31:0] res  [3] = '{32'hFFFF0000, 32'hFFFF0001, 32'hFFFF0002};
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(pc_model);
         exp_q.push_back(res[k]);
         serve(prog[k], 0);
         pc_model += 4;
         exp = exp_q.pop_front();
         n_cmp++; if (b_ok !== 1'b1 || b_addr !== exp) begin n_err++; $display("FAIL lui_fetch%0d: got %h expected %h", k, b_addr, exp); end
         @(negedge clk);
         exp = exp_q.pop_front();
         n_cmp++; if (register_v0 !== exp) begin n_err++; $display("FAIL lui_v0_%0d: got %h expected %h", k, register_v0, exp); end
      end
   endtask

   task automatic test_waitrequest();
      exp_q.push_back(pc_model);
      serve(32'h24051234, 5);       // addiu r5, r0, 0x1234
      pc_model += 4;
      exp = exp_q.pop_front();
      n_cmp++; if (b_ok !== 1'b1 || b_addr !== exp || b_stable !== 1'b1) begin n_err++; $display("FAIL wr_fetch1: got %h stable=%b expected %h stable=1", b_addr, b_stable, exp); end
      exp_q.push_back(pc_model);
      serve(32'hACA2FFFC, 5);       // sw r2, -4(r5)
      pc_model += 4;
      exp = exp_q.pop_front();
      n_cmp++; if (b_ok !== 1'b1 || b_addr !== exp || b_stable !== 1'b1) begin n_err++; $display("FAIL wr_fetch2: got %h stable=%b expected %h stable=1", b_addr, b_stable, exp); end
      exp_q.push_back(32'h00001230);
      exp_q.push_back(32'hFFFF0002);
      serve(32'h0, 5);
      exp = exp_q.pop_front();
      n_cmp++; if (b_ok !== 1'b1 || b_addr !== exp) begin n_err++; $display("FAIL sw_addr: got %h expected %h", b_addr, exp); end
      n_cmp++; if (b_wr !== 1'b1 || b_rd !== 1'b0) begin n_err++; $display("FAIL sw_strobes: got rd=%b wr=%b expected rd=0 wr=1", b_rd, b_wr); end
      exp = exp_q.pop_front();
      n_cmp++; if (b_wd !== exp) begin n_err++; $display("FAIL sw_data: got %h expected %h", b_wd, exp); end
      n_cmp++; if (b_be !== 4'b1111) begin n_err++; $display("FAIL sw_be: got %b expected 1111", b_be); end
      n_cmp++; if (b_stable !== 1'b1) begin n_err++; $display("FAIL sw_stable: got %b expected 1", b_stable); end
   endtask

   task automatic test_branch();
      logic [31:0] br_pc;
      br_pc = pc_model;
      exp_q.push_back(pc_model);
      serve(32'h10000002, 0);       // beq r0, r0, +2
      exp = exp_q.pop_front();
      n_cmp++; if (b_ok !== 1'b1 || b_addr !== exp) begin n_err++; $display("FAIL beq_fetch: got %h expected %h", b_addr, exp); end
      exp_q.push_back(br_pc + 32'd4);
      exp_q.push_back(32'd3);
      serve(32'h24020003, 0);       // delay slot: addiu r2, r0, 3
      exp = exp_q.pop_front();
      n_cmp++; if (b_ok !== 1'b1 || b_addr !== exp) begin n_err++; $display("FAIL slot_fetch: got %h expected %h", b_addr, exp); end
      @(negedge clk);
      exp = exp_q.pop_front();
      n_cmp++; if (register_v0 !== exp) begin n_err++; $display("FAIL slot_v0: got %h expected %h", register_v0, exp); end
      pc_model = br_pc + 32'd12;
   endtask

   task automatic test_halt();
      int viol;
      exp_q.push_back(pc_model);
      serve(32'h00000008, 0);       // jr r0
      exp = exp_q.pop_front();
      n_cmp++; if (b_ok !== 1'b1 || b_addr !== exp) begin n_err++; $display("FAIL jr_fetch: got %h expected %h", b_addr, exp); end
      n_cmp++; if (active !== 1'b1) begin n_err++; $display("FAIL jr_active: got %b expected 1", active); end
      exp_q.push_back(pc_model + 32'd4);
      exp_q.push_back(32'd7);
      serve(32'h24020007, 0);       // delay slot: addiu r2, r0, 7
      exp = exp_q.pop_front();
      n_cmp++; if (b_ok !== 1'b1 || b_addr !== exp) begin n_err++; $display("FAIL halt_slot_fetch: got %h expected %h", b_addr, exp); end
      @(negedge clk);
      exp = exp_q.pop_front();
      n_cmp++; if (register_v0 !== exp) begin n_err++; $display("FAIL halt_v0: got %h expected %h", register_v0, exp); end
      n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL halt_active: got %b expected 0", active); end
      viol = 0;
      waitrequest = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (read !== 1'b0 || write !== 1'b0 || active !== 1'b0) viol++;
         @(negedge clk);
      end
      waitrequest = 1'b1;
      n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL halt_quiet: got %0d bus/active violations expected 0", viol); end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_addiu();
      test_lui();
      test_waitrequest();
      test_branch();
      test_halt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
